// File: rtl/uci_host_if.sv
// Shared move/special types and the command/character channel bundle between
// the UCI host and its user (slave = uci_host side).
package uci_pkg;
  typedef enum logic [2:0] {
    SPECIAL_NONE           = 3'd0,
    SPECIAL_CASTLE         = 3'd1,
    SPECIAL_EN_PASSANT     = 3'd2,
    SPECIAL_DOUBLE_PUSH    = 3'd3,
    SPECIAL_PROMOTE_KNIGHT = 3'd4,
    SPECIAL_PROMOTE_BISHOP = 3'd5,
    SPECIAL_PROMOTE_ROOK   = 3'd6,
    SPECIAL_PROMOTE_QUEEN  = 3'd7
  } special_t;

  typedef struct packed {
    logic [2:0] src_fil;
    logic [2:0] src_rnk;
    logic [2:0] dst_fil;
    logic [2:0] dst_rnk;
    special_t   special;
  } move_t;

  localparam logic [1:0] CMD_UCI      = 2'd0;
  localparam logic [1:0] CMD_POSITION = 2'd1;
  localparam logic [1:0] CMD_MOVE     = 2'd2;
  localparam logic [1:0] CMD_GO       = 2'd3;
endpackage

interface uci_host_if;
  import uci_pkg::*;

  logic [1:0] cmd_in;
  move_t      move_in;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic [7:0] char_out;
  logic       char_out_valid;
  logic       char_out_ready;
  logic [7:0] char_in;
  logic       char_in_valid;
  logic       char_in_ready;
  logic       engine_busy_out;
  logic       uciok_out;
  move_t      best_move_out;
  logic       best_move_valid_out;
  logic       info_line_out;
  logic       parse_error_out;

  modport slave (
    input  cmd_in, move_in, cmd_valid_in, char_out_ready, char_in, char_in_valid,
    output cmd_ready_out, char_out, char_out_valid, char_in_ready, engine_busy_out,
           uciok_out, best_move_out, best_move_valid_out, info_line_out, parse_error_out
  );

  modport master (
    output cmd_in, move_in, cmd_valid_in, char_out_ready, char_in, char_in_valid,
    input  cmd_ready_out, char_out, char_out_valid, char_in_ready, engine_busy_out,
           uciok_out, best_move_out, best_move_valid_out, info_line_out, parse_error_out
  );
endinterface

// File: rtl/uci_host.sv
// Host side of the UCI character link: serialises commands to the engine and
// classifies the engine's reply lines into uciok / bestmove / info events.
//   state   | meaning
//   TX_IDLE | waiting for a command (blocked while the engine is searching)
//   TX_SEND | streaming the latched command string, one char per handshake
//   RX_LINE | collecting a reply line into the buffer
//   RX_DISC | line overflowed the buffer, dropping chars until newline
module uci_host
  import uci_pkg::*;
#(
  parameter int LINE_LEN = 16
) (
  input logic       clk_in,
  input logic       rst_in,
  uci_host_if.slave bus
);

  localparam int CW = $clog2(LINE_LEN + 1);
  localparam int IW = $clog2(LINE_LEN);

  localparam logic [7:0] POS_CHARS [18] = '{
    "p", "o", "s", "i", "t", "i", "o", "n", " ",
    "s", "t", "a", "r", "t", "p", "o", "s", 8'h0A
  };

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {RX_LINE, RX_DISC} rx_state_t;

  function automatic logic [7:0] file_chr(logic [2:0] f);
    return 8'h61 + {5'd0, f};
  endfunction

  function automatic logic [7:0] rank_chr(logic [2:0] r);
    return 8'h31 + {5'd0, r};
  endfunction

  function automatic logic [7:0] promo_chr(special_t s);
    case (s)
      SPECIAL_PROMOTE_KNIGHT: return "n";
      SPECIAL_PROMOTE_BISHOP: return "b";
      SPECIAL_PROMOTE_ROOK:   return "r";
      SPECIAL_PROMOTE_QUEEN:  return "q";
      default:                return 8'h0A;
    endcase
  endfunction

  function automatic logic is_file(logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h68);
  endfunction

  function automatic logic is_rank(logic [7:0] c);
    return (c >= 8'h31) && (c <= 8'h38);
  endfunction

  function automatic logic [2:0] sq_idx(logic [7:0] c, logic [7:0] base);
    logic [7:0] d;
    d = c - base;
    return d[2:0];
  endfunction

  function automatic logic is_promo(logic [7:0] c);
    return (c == "n") || (c == "b") || (c == "r") || (c == "q");
  endfunction

  function automatic special_t promo_of(logic [7:0] c);
    case (c)
      "n":     return SPECIAL_PROMOTE_KNIGHT;
      "b":     return SPECIAL_PROMOTE_BISHOP;
      "r":     return SPECIAL_PROMOTE_ROOK;
      "q":     return SPECIAL_PROMOTE_QUEEN;
      default: return SPECIAL_NONE;
    endcase
  endfunction

  // ---------------- TX ----------------
  tx_state_t  tx_state;
  logic [1:0] cmd_q;
  move_t      move_q;
  logic [4:0] tx_idx;
  logic       tx_valid;
  logic       live;
  logic       busy;
  logic       cmd_ready;
  logic       tx_hs;
  logic       tx_last;
  logic       go_done;
  logic [4:0] tx_last_idx;
  logic [7:0] tx_char;

  // live keeps cmd_ready low while reset is asserted
  assign cmd_ready = live && (tx_state == TX_IDLE) && !busy;
  assign tx_hs     = tx_valid && bus.char_out_ready;
  assign tx_last   = (tx_idx == tx_last_idx);
  assign go_done   = tx_hs && tx_last && (cmd_q == CMD_GO);

  always_comb begin
    tx_last_idx = 5'd2;
    case (cmd_q)
      CMD_UCI:      tx_last_idx = 5'd3;
      CMD_POSITION: tx_last_idx = 5'd17;
      CMD_MOVE:     tx_last_idx = move_q.special[2] ? 5'd10 : 5'd9;
      default:      tx_last_idx = 5'd2;
    endcase
  end

  always_comb begin
    tx_char = 8'h0A;
    case (cmd_q)
      CMD_UCI: begin
        case (tx_idx)
          5'd0:    tx_char = "u";
          5'd1:    tx_char = "c";
          5'd2:    tx_char = "i";
          default: tx_char = 8'h0A;
        endcase
      end
      CMD_POSITION: begin
        if (tx_idx < 5'd18) tx_char = POS_CHARS[tx_idx];
      end
      CMD_MOVE: begin
        case (tx_idx)
          5'd0:    tx_char = "m";
          5'd1:    tx_char = "o";
          5'd2:    tx_char = "v";
          5'd3:    tx_char = "e";
          5'd4:    tx_char = " ";
          5'd5:    tx_char = file_chr(move_q.src_fil);
          5'd6:    tx_char = rank_chr(move_q.src_rnk);
          5'd7:    tx_char = file_chr(move_q.dst_fil);
          5'd8:    tx_char = rank_chr(move_q.dst_rnk);
          5'd9:    tx_char = promo_chr(move_q.special);
          default: tx_char = 8'h0A;
        endcase
      end
      default: begin
        case (tx_idx)
          5'd0:    tx_char = "g";
          5'd1:    tx_char = "o";
          default: tx_char = 8'h0A;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_state <= TX_IDLE;
      tx_valid <= 1'b0;
      tx_idx   <= 5'd0;
      cmd_q    <= CMD_UCI;
      move_q   <= '0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (bus.cmd_valid_in && cmd_ready) begin
            cmd_q    <= bus.cmd_in;
            move_q   <= bus.move_in;
            tx_idx   <= 5'd0;
            tx_valid <= 1'b1;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_hs) begin
            if (tx_last) begin
              tx_valid <= 1'b0;
              tx_state <= TX_IDLE;
            end else begin
              tx_idx <= tx_idx + 5'd1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [7:0]    rx_buf [LINE_LEN];
  logic          rx_take, rx_nl, line_end, buf_we;
  logic          is_uciok, is_info, is_bm, sq_ok, bm_ok;
  move_t         bm_move;
  logic          uciok_q, bm_valid_q, info_q, perr_q;
  move_t         best_q;

  assign rx_take  = bus.char_in_valid && (bus.char_in != 8'h0D) && (bus.char_in != 8'h00);
  assign rx_nl    = rx_take && (bus.char_in == 8'h0A);
  assign line_end = rx_nl && (rx_state == RX_LINE);
  assign buf_we   = rx_take && !rx_nl && (rx_state == RX_LINE) && (rx_cnt != CW'(LINE_LEN));

  assign is_uciok = (rx_cnt == CW'(5)) &&
                    ({rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]} == "uciok");
  assign is_info  = (rx_cnt >= CW'(5)) &&
                    ({rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]} == "info ");
  assign is_bm    = (rx_cnt >= CW'(9)) &&
                    ({rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4],
                      rx_buf[5], rx_buf[6], rx_buf[7], rx_buf[8]} == "bestmove ");
  assign sq_ok    = is_file(rx_buf[9])  && is_rank(rx_buf[10]) &&
                    is_file(rx_buf[11]) && is_rank(rx_buf[12]);
  assign bm_ok    = is_bm && sq_ok &&
                    ((rx_cnt == CW'(13)) || ((rx_cnt == CW'(14)) && is_promo(rx_buf[13])));

  always_comb begin
    bm_move         = '0;
    bm_move.src_fil = sq_idx(rx_buf[9],  8'h61);
    bm_move.src_rnk = sq_idx(rx_buf[10], 8'h31);
    bm_move.dst_fil = sq_idx(rx_buf[11], 8'h61);
    bm_move.dst_rnk = sq_idx(rx_buf[12], 8'h31);
    bm_move.special = (rx_cnt == CW'(14)) ? promo_of(rx_buf[13]) : SPECIAL_NONE;
  end

  always_ff @(posedge clk_in) begin
    if (buf_we) rx_buf[rx_cnt[IW-1:0]] <= bus.char_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_state   <= RX_LINE;
      rx_cnt     <= '0;
      uciok_q    <= 1'b0;
      bm_valid_q <= 1'b0;
      info_q     <= 1'b0;
      perr_q     <= 1'b0;
      best_q     <= '0;
    end else begin
      uciok_q    <= 1'b0;
      bm_valid_q <= 1'b0;
      info_q     <= 1'b0;
      perr_q     <= 1'b0;
      if (rx_take) begin
        case (rx_state)
          RX_LINE: begin
            if (rx_nl) begin
              rx_cnt  <= '0;
              uciok_q <= is_uciok;
              info_q  <= is_info;
              perr_q  <= is_bm && !bm_ok;
              if (bm_ok) begin
                best_q     <= bm_move;
                bm_valid_q <= 1'b1;
              end
            end else if (rx_cnt == CW'(LINE_LEN)) begin
              rx_cnt   <= '0;
              rx_state <= RX_DISC;
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end
          default: begin
            if (rx_nl) begin
              rx_cnt   <= '0;
              rx_state <= RX_LINE;
            end
          end
        endcase
      end
    end
  end

  // a GO finishing in the same cycle as a bestmove keeps the engine busy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy <= 1'b0;
    end else if (go_done) begin
      busy <= 1'b1;
    end else if (line_end && is_bm) begin
      busy <= 1'b0;
    end
  end

  assign bus.cmd_ready_out       = cmd_ready;
  assign bus.char_out            = tx_valid ? tx_char : 8'h00;
  assign bus.char_out_valid      = tx_valid;
  assign bus.char_in_ready       = 1'b1;
  assign bus.engine_busy_out     = busy;
  assign bus.uciok_out           = uciok_q;
  assign bus.best_move_out       = best_q;
  assign bus.best_move_valid_out = bm_valid_q;
  assign bus.info_line_out       = info_q;
  assign bus.parse_error_out     = perr_q;

endmodule

// File: tb/tb_uci_host.sv
// Bench for uci_host: command and reply-line tables with scoreboard queues for
// transmitted characters and decoded events, plus reset/busy corner sequences.
module tb_uci_host;
  import uci_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uci_host_if bus();

  uci_host #(.LINE_LEN(16)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  localparam logic [3:0] EV_UCIOK = 4'b1000;
  localparam logic [3:0] EV_BM    = 4'b0100;
  localparam logic [3:0] EV_INFO  = 4'b0010;
  localparam logic [3:0] EV_PERR  = 4'b0001;

  typedef struct {
    logic [1:0] cmd;
    move_t      mv;
    string      exp;
    logic       toggle;
  } tx_vec_t;

  typedef struct {
    string      line;
    logic [3:0] kind;
    move_t      mv;
  } rx_vec_t;

  typedef struct {
    logic [3:0] kind;
    move_t      best;
  } rx_ev_t;

  int      checks = 0;
  int      errors = 0;
  byte     exp_q[$];
  rx_ev_t  rx_exp[$];
  move_t   exp_best = '0;
  tx_vec_t tx_tab[7];
  rx_vec_t rx_tab[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic move_t mk(int sf, int sr, int df, int dr, special_t sp);
    move_t m;
    m.src_fil = 3'(sf);
    m.src_rnk = 3'(sr);
    m.dst_fil = 3'(df);
    m.dst_rnk = 3'(dr);
    m.special = sp;
    return m;
  endfunction

  function automatic tx_vec_t tv(logic [1:0] c, move_t m, string s, logic t);
    tx_vec_t r;
    r.cmd = c; r.mv = m; r.exp = s; r.toggle = t;
    return r;
  endfunction

  function automatic rx_vec_t rv(string s, logic [3:0] k, move_t m);
    rx_vec_t r;
    r.line = s; r.kind = k; r.mv = m;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // TX scoreboard: each handshake pops one expected char; stalled chars must hold
  logic       hold_pending = 1'b0;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else if (bus.char_out_valid) begin
      if (hold_pending) chk("tx_hold", 32'(bus.char_out), 32'(held));
      if (bus.char_out_ready) begin
        if (exp_q.size() == 0) chk("tx_extra_char", 32'(bus.char_out), 32'hFFFF_FFFF);
        else chk("tx_char", 32'(bus.char_out), 32'(exp_q.pop_front()));
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held = bus.char_out;
      end
    end else begin
      if (hold_pending) chk("tx_hold_valid", 32'(bus.char_out_valid), 32'd1);
      hold_pending = 1'b0;
    end
  end

  // RX scoreboard: every pulse cycle must match the next queued event
  logic [3:0] ev_kind;
  rx_ev_t     ev;
  always @(negedge clk) begin
    if (rst_n) begin
      ev_kind = {bus.uciok_out, bus.best_move_valid_out, bus.info_line_out, bus.parse_error_out};
      if (ev_kind != 4'd0) begin
        if (rx_exp.size() == 0) begin
          chk("rx_unexpected_pulse", 32'(ev_kind), 32'd0);
        end else begin
          ev = rx_exp.pop_front();
          chk("rx_kind", 32'(ev_kind), 32'(ev.kind));
          chk("rx_best", 32'(bus.best_move_out), 32'(ev.best));
        end
      end
    end
  end

  task automatic run_tx(input tx_vec_t v, input logic exp_busy);
    int    g;
    string s;
    s = v.exp;
    g = 0;
    while (!bus.cmd_ready_out && g < 100) begin tick(); g++; end
    if (!bus.cmd_ready_out) chk("cmd_ready_wait", 32'(bus.cmd_ready_out), 32'd1);
    bus.cmd_in = v.cmd;
    bus.move_in = v.mv;
    bus.cmd_valid_in = 1'b1;
    bus.char_out_ready = 1'b1;
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    tick();
    bus.cmd_valid_in = 1'b0;
    bus.cmd_in = 2'd0;
    bus.move_in = '0;
    g = 0;
    while ((exp_q.size() != 0 || bus.char_out_valid) && g < 200) begin
      tick();
      g++;
      if (v.toggle) bus.char_out_ready = !bus.char_out_ready;
    end
    chk("tx_cycles", 32'(g), v.toggle ? 32'(2 * s.len() - 1) : 32'(s.len()));
    chk("tx_drained", 32'(exp_q.size()), 32'd0);
    bus.char_out_ready = 1'b1;
    chk("busy_after_tx", 32'(bus.engine_busy_out), 32'(exp_busy));
    chk("ready_after_tx", 32'(bus.cmd_ready_out), 32'(!exp_busy));
  endtask

  task automatic send_line(input rx_vec_t v);
    string  s;
    rx_ev_t e;
    s = v.line;
    if (v.kind != 4'd0) begin
      if (v.kind == EV_BM) exp_best = v.mv;
      e.kind = v.kind;
      e.best = exp_best;
      rx_exp.push_back(e);
    end
    for (int i = 0; i < s.len(); i++) begin
      bus.char_in = s[i];
      bus.char_in_valid = 1'b1;
      tick();
    end
    bus.char_in_valid = 1'b0;
    bus.char_in = 8'h00;
    repeat (3) tick();
    chk("rx_drained", 32'(rx_exp.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_in = 2'd0;
    bus.move_in = '0;
    bus.cmd_valid_in = 1'b0;
    bus.char_out_ready = 1'b1;
    bus.char_in = 8'h00;
    bus.char_in_valid = 1'b0;

    tx_tab[0] = tv(CMD_UCI,      mk(0,0,0,0,SPECIAL_NONE),           "uci\n", 1'b0);
    tx_tab[1] = tv(CMD_POSITION, mk(0,0,0,0,SPECIAL_NONE),           "position startpos\n", 1'b0);
    tx_tab[2] = tv(CMD_MOVE,     mk(4,1,4,3,SPECIAL_NONE),           "move e2e4\n", 1'b1);
    tx_tab[3] = tv(CMD_MOVE,     mk(0,6,0,7,SPECIAL_PROMOTE_QUEEN),  "move a7a8q\n", 1'b0);
    tx_tab[4] = tv(CMD_MOVE,     mk(4,0,6,0,SPECIAL_CASTLE),         "move e1g1\n", 1'b1);
    tx_tab[5] = tv(CMD_MOVE,     mk(7,6,7,7,SPECIAL_PROMOTE_KNIGHT), "move h7h8n\n", 1'b0);
    tx_tab[6] = tv(CMD_GO,       mk(1,2,3,4,SPECIAL_NONE),           "go\n", 1'b0);

    rx_tab[0]  = rv("id name River\015\nuciok\n", EV_UCIOK, '0);
    rx_tab[1]  = rv("info depth 3\n",          EV_INFO, '0);
    rx_tab[2]  = rv("bestmove z9a1\n",         EV_PERR, '0);
    rx_tab[3]  = rv("bestmove e7e8r\n",        EV_BM,   mk(4,6,4,7,SPECIAL_PROMOTE_ROOK));
    rx_tab[4]  = rv("bestmove e2e4x\n",        EV_PERR, '0);
    rx_tab[5]  = rv("uciokx\n",                4'd0,    '0);
    rx_tab[6]  = rv("\n",                      4'd0,    '0);
    rx_tab[7]  = rv("info\n",                  4'd0,    '0);
    rx_tab[8]  = rv("xxxxxxxbestmove e2e4\n",  4'd0,    '0);
    rx_tab[9]  = rv("bestmove e2e4\n",         EV_BM,   mk(4,1,4,3,SPECIAL_NONE));
    rx_tab[10] = rv("bestmove a1h8\015\n",     EV_BM,   mk(0,0,7,7,SPECIAL_NONE));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char_out_valid", 32'(bus.char_out_valid), 32'd0);
    chk("rst_char_out", 32'(bus.char_out), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_out), 32'd0);
    chk("rst_char_in_ready", 32'(bus.char_in_ready), 32'd1);
    chk("rst_busy", 32'(bus.engine_busy_out), 32'd0);
    chk("rst_best", 32'(bus.best_move_out), 32'd0);
    chk("rst_pulses", 32'({bus.uciok_out, bus.best_move_valid_out, bus.info_line_out,
                           bus.parse_error_out}), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("ready_after_rst", 32'(bus.cmd_ready_out), 32'd1);

    foreach (tx_tab[i]) run_tx(tx_tab[i], tx_tab[i].cmd == CMD_GO);

    // engine busy: further commands must not be accepted
    bus.cmd_in = CMD_UCI;
    bus.cmd_valid_in = 1'b1;
    repeat (4) begin
      tick();
      chk("busy_blocks_cmd", 32'(bus.char_out_valid), 32'd0);
    end
    bus.cmd_valid_in = 1'b0;

    send_line(rv("bestmove g1f3\n", EV_BM, mk(6,0,5,2,SPECIAL_NONE)));
    chk("busy_cleared", 32'(bus.engine_busy_out), 32'd0);
    chk("ready_after_bm", 32'(bus.cmd_ready_out), 32'd1);

    foreach (rx_tab[i]) send_line(rx_tab[i]);
    chk("best_hold", 32'(bus.best_move_out), 32'(mk(0,0,7,7,SPECIAL_NONE)));

    // reset in the middle of a POSITION string
    bus.cmd_in = CMD_POSITION;
    bus.cmd_valid_in = 1'b1;
    bus.char_out_ready = 1'b1;
    begin
      string s;
      s = "position startpos\n";
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end
    tick();
    bus.cmd_valid_in = 1'b0;
    repeat (4) tick();
    chk("mid_send_valid", 32'(bus.char_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_send_valid", 32'(bus.char_out_valid), 32'd0);
    chk("rst_mid_send_best", 32'(bus.best_move_out), 32'd0);
    exp_q.delete();
    exp_best = '0;
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("no_resume_after_rst", 32'(bus.char_out_valid), 32'd0);
    end
    run_tx(tx_tab[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uci_host.md
Name: uci_host

Overview:
- Host-side counterpart to the on-FPGA UCI engine interface.
- Turns high-level command requests into UCI character streams sent to the engine, and parses the engine's reply characters into decoded events (uciok, bestmove, info).
- Used for self-play, board-UI integration and loopback testing against the engine's UCI front end, through the same 8-bit valid/ready character channels.

Parameters:
- LINE_LEN, 16, receive line buffer depth in characters; longer lines are discarded.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- cmd_in  input  2  command select: 0=UCI, 1=POSITION, 2=MOVE, 3=GO
- move_in  input  move_t  move payload for MOVE; sampled on command accept
- cmd_valid_in  input  1  command request valid
- cmd_ready_out  output  1  command accept ready
- char_out  output  8  character to engine
- char_out_valid  output  1  char_out valid
- char_out_ready  input  1  engine accepts char_out
- char_in  input  8  character from engine
- char_in_valid  input  1  char_in valid
- char_in_ready  output  1  always 1
- engine_busy_out  output  1  GO sent, bestmove not yet received
- uciok_out  output  1  one-cycle pulse on an "uciok" line
- best_move_out  output  move_t  last decoded best move
- best_move_valid_out  output  1  one-cycle pulse with a new best_move_out
- info_line_out  output  1  one-cycle pulse on a line starting "info "
- parse_error_out  output  1  one-cycle pulse on a malformed bestmove line

Behaviour:
- Reset (rst_in low, asynchronous): all outputs 0 except char_in_ready=1. TX goes to IDLE. RX goes to LINE with an empty buffer. best_move_out=0, engine_busy_out=0.
- Reset mid-transfer aborts the current string. No partial continuation after reset release.

TX FSM (IDLE, SEND):
- cmd_ready_out = (state==IDLE) && !engine_busy_out.
- Accept happens on cmd_valid_in && cmd_ready_out. The command and move_in are latched.
- Next cycle: SEND, with char_out_valid=1 and char_out = first character.
- The character index advances only on char_out_valid && char_out_ready. char_out is held stable otherwise.
- Strings:
  - UCI: "uci\n"
  - POSITION: "position startpos\n"
  - MOVE: "move " + src file + src rank + dst file + dst rank [+ promo] + "\n"
  - GO: "go\n"
- Move encoding:
  - file char = "a"+fil[2:0]; rank char = "1"+rnk[2:0].
  - promo char: SPECIAL_PROMOTE_KNIGHT/BISHOP/ROOK/QUEEN -> n/b/r/q; any other special -> no promo character.
- The handshake on "\n" returns TX to IDLE with char_out_valid=0 in the following cycle.
- Back-to-back: a new command is accepted no earlier than the cycle after the FSM returns to IDLE.
- The handshake on the final "\n" of GO sets engine_busy_out the next cycle.

RX (LINE, DISCARD):
- Characters arrive on every char_in_valid; char_in_ready is tied to 1.
- 0x0D and 0x00 are ignored in both states.
- In LINE, a non-newline character is appended to the buffer. Appending character LINE_LEN+1 moves RX to DISCARD.
- In DISCARD, characters are dropped until "\n". The "\n" returns RX to LINE with an empty buffer and produces no pulse.
- On "\n" in LINE, the buffer is classified, a pulse is issued the following cycle, and the buffer is cleared:
  - exactly "uciok": uciok_out.
  - prefix "info ": info_line_out.
  - prefix "bestmove " followed by exactly 4 chars, or 4 chars plus one of n/b/r/q, all files in a..h and ranks in 1..8:
    - best_move_out updated, with special = matching PROMOTE code or SPECIAL_NONE.
    - best_move_valid_out pulse.
    - engine_busy_out cleared.
  - prefix "bestmove " with any other tail: parse_error_out; engine_busy_out cleared.
  - anything else, including empty lines and "id ..." lines: no pulse.
- If the busy set and clear occur in the same cycle, set wins.
- best_move_out holds its value until the next valid bestmove or reset.

Test Plan:
- Reset, then cmd_in=0 accepted with char_out_ready=1 -> char_out sequence 0x75,0x63,0x69,0x0A on 4 consecutive cycles; cmd_ready_out returns high after.
- MOVE with src (4,1), dst (4,3), SPECIAL_NONE, char_out_ready toggling 1/0 -> "move e2e4\n", each char held while ready=0, no duplicates or drops.
- MOVE with src (0,6), dst (0,7), SPECIAL_PROMOTE_QUEEN -> "move a7a8q\n".
- GO sent; engine_busy_out=1 and cmd_ready_out=0; RX receives "bestmove g1f3\n" -> best_move_out src(6,0) dst(5,2) special NONE, one-cycle best_move_valid_out, busy cleared.
- RX "id name River\r\nuciok\n" -> only a single uciok_out pulse. "info depth 3\n" -> info_line_out. "bestmove z9a1\n" -> parse_error_out, best_move_out unchanged.
- RX a 20-char line ending in "bestmove e2e4" -> no pulses. A following "bestmove e2e4\n" decodes correctly. rst_in low mid-SEND -> char_out_valid=0 immediately.
